// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit: issues word-aligned fetches, buffers returned words with PCs.
// Optional performance counters are enabled by defining IF_PREFETCH_PERF_EN.

module if_prefetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [15:0] perf_drop_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 2;

    // Architectural state
    logic [31:0]      fetch_pc_q, fetch_pc_n;
    logic [31:0]      rsp_pc_q, rsp_pc_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] live_q, live_n;
    logic [CNT_W-1:0] drop_q, drop_n;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];

    // Per-cycle events
    logic [SUM_W-1:0] occupancy;
    logic [31:0]      redirect_target;
    logic [1:0]       unused_redirect_lsb;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_take;
    logic             fifo_push;
    logic             fifo_pop;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = redirect_pc[1:0];

    // Capacity is reserved at issue: FIFO entries plus everything still in flight.
    assign occupancy = SUM_W'(count_q) + SUM_W'(live_q) + SUM_W'(drop_q);

    assign imem_req_valid = !reset && !redirect_valid && (occupancy < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Stale responses are consumed first; a response with nothing outstanding is ignored.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_take = imem_rsp_valid && (drop_q == '0) && (live_q != '0);

    assign fifo_push = rsp_take && !redirect_valid;
    assign fifo_pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;

    // Next-state logic; redirect overrides all normal progress.
    always_comb begin
        fetch_pc_n = fetch_pc_q;
        rsp_pc_n   = rsp_pc_q;
        count_n    = count_q;
        live_n     = live_q;
        drop_n     = drop_q;
        rd_ptr_n   = rd_ptr_q;
        wr_ptr_n   = wr_ptr_q;

        if (redirect_valid) begin
            fetch_pc_n = redirect_target;
            rsp_pc_n   = redirect_target;
            count_n    = '0;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
            live_n     = '0;
            drop_n     = drop_q + live_q - CNT_W'(rsp_drop || rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc_n = fetch_pc_q + 32'd4;
            end
            live_n = live_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
            drop_n = drop_q - CNT_W'(rsp_drop);
            if (fifo_push) begin
                wr_ptr_n = wr_ptr_q + PTR_W'(1);
                rsp_pc_n = rsp_pc_q + 32'd4;
            end
            if (fifo_pop) begin
                rd_ptr_n = rd_ptr_q + PTR_W'(1);
            end
            count_n = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            live_q     <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_n;
            rsp_pc_q   <= rsp_pc_n;
            count_q    <= count_n;
            live_q     <= live_n;
            drop_q     <= drop_n;
            rd_ptr_q   <= rd_ptr_n;
            wr_ptr_q   <= wr_ptr_n;
        end
    end

    // Entry storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (!reset && fifo_push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic perf_drop_inc;
    logic perf_stall_inc;

    // A response arriving with a redirect is discarded even if it was live.
    assign perf_drop_inc  = rsp_drop || (redirect_valid && rsp_take);
    assign perf_stall_inc = !inst_valid && !redirect_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_drop_cnt  <= 16'h0;
            perf_stall_cnt <= 16'h0;
        end else begin
            if (perf_drop_inc && (perf_drop_cnt != 16'hFFFF)) begin
                perf_drop_cnt <= perf_drop_cnt + 16'd1;
            end
            if (perf_stall_inc && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch front end upstream of the single-cycle decode/execute datapath.
- Issues word-aligned fetch requests to an instruction memory whose latency is variable and whose responses return in order.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles control-flow redirects (branch, j, jal, jr) by flushing the FIFO and discarding responses still in flight.

Parameters:
- FIFO_DEPTH, 4, instruction FIFO entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  byte address of the request; bits [1:0] always 0.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response word valid; cannot be back-pressured.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  pipeline redirect this cycle.
- redirect_pc  input  32  redirect target; bits [1:0] ignored.
- inst_valid  output  1  head FIFO entry valid.
- inst_data  output  32  head instruction.
- inst_pc  output  32  byte PC of the head instruction.
- inst_ready  input  1  decode consumes the head this cycle.

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`. All state updates on the rising edge of `clock`.
- Reset state:
  - fetch_pc = RESET_PC and rsp_pc = RESET_PC.
  - FIFO count = 0, live_cnt = 0, drop_cnt = 0.
  - Outputs: imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
  - A reset asserted mid-operation abandons all in-flight requests. Responses arriving after reset are not dropped; the memory is reset alongside this block.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (count + live_cnt + drop_cnt < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On fire (imem_req_valid && imem_req_ready): fetch_pc += 4, live_cnt += 1.
  - fetch_pc wraps from 32'hFFFF_FFFC to 0.
  - imem_req_valid and imem_req_addr stay stable until fire or redirect.
- Response handling (every imem_rsp_valid cycle):
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise, if live_cnt > 0: push {imem_rsp_data, rsp_pc}, then rsp_pc += 4 and live_cnt -= 1.
  - If both counters are 0: the response is ignored (protocol error, no state change).
- FIFO:
  - Registered, so a response in cycle N gives inst_valid in cycle N+1. No bypass.
  - inst_valid = (count != 0). inst_data and inst_pc hold stable while inst_valid && !inst_ready.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible because capacity is reserved at issue; the verifier asserts count <= FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Redirect (highest priority; cycle N):
  - FIFO flushed: count = 0, pointers reset.
  - A pop in cycle N is void; decode treats a redirect as a squash.
  - drop_cnt <= drop_cnt + live_cnt − (1 if a response arrives in N and drop_cnt was > 0 — or live_cnt > 0 when drop_cnt == 0); live_cnt <= 0. A response arriving in N is always discarded.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - No request issues in cycle N. The first new-target request issues at N+1 if capacity allows.
  - inst_valid = 0 at N+1.
  - Back-to-back redirects: the last one wins.
- Counter widths: clog2(FIFO_DEPTH)+1 bits.
- Invariant: count + live_cnt + drop_cnt <= FIFO_DEPTH.

Optional Feature:
- Macro: IF_PREFETCH_PERF_EN.
- When defined:
  - Adds output perf_drop_cnt (16 bits), which increments on every discarded response and saturates at 16'hFFFF.
  - Adds output perf_stall_cnt (16 bits), which increments on every cycle with inst_valid == 0 and no redirect, and saturates at 16'hFFFF.
  - Both counters clear on reset.
- When undefined: neither port nor either counter exists. All other behaviour is identical.

Test Plan:
- Reset, then zero-latency memory with ready=1 and inst_ready=1 → requests at 0x0, 0x4, 0x8; inst_pc sequence 0x0, 0x4, 0x8 with matching data, one per cycle once the pipe is filled.
- inst_ready=0 for 20 cycles (FIFO_DEPTH=4) → exactly 4 fires, then imem_req_valid=0 and count=4. Restoring inst_ready=1 delivers PCs 0x0–0xC in order, and fetch resumes at 0x10.
- Memory latency 3 cycles with 2 requests outstanding; redirect_pc=0x0000_0103 → both stale responses discarded, no stale inst_valid, next request addr=0x0000_0100, first delivered inst_pc=0x100.
- Redirect in the same cycle as a response, and as a pop with count=2 → response discarded, FIFO empty at N+1, no request issued in cycle N.
- Redirect to 0xFFFF_FFF8 → requests at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, with inst_pc following the same wrap.
- With IF_PREFETCH_PERF_EN defined: the third scenario gives perf_drop_cnt=2. Reset mid-stream returns all outputs to their reset values on the next edge, and the first request after reset is at RESET_PC.
